// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, FSM states, queue payload and
// instruction constants that the decoder and execute stages also use.
package ifu_fetch_pkg;

  localparam logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000;
  localparam int          QDEPTH      = 2;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Two-entry {inst, pc} FIFO between instruction memory and the decoder.
// Entry 0 is always the head; a dequeue shifts entry 1 down.
module ifu_fetch_queue
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        enq,
  input  logic [31:0] enq_inst,
  input  logic [63:0] enq_pc,
  input  logic        deq,
  output logic [31:0] head_inst,
  output logic [63:0] head_pc,
  output logic [1:0]  count
);

  fetch_entry_t ent_q [QDEPTH];
  fetch_entry_t ent_d [QDEPTH];
  logic [1:0]   count_q, count_d;
  logic [1:0]   count_after_deq;
  logic         do_deq, do_enq;

  always_comb begin
    ent_d           = ent_q;
    count_d         = count_q;
    do_deq          = deq && (count_q != 2'd0);
    count_after_deq = count_q - {1'b0, do_deq};
    // Writing at the post-dequeue count lets enqueue and dequeue share a cycle
    do_enq          = enq && (count_after_deq < 2'(QDEPTH));
    if (flush) begin
      count_d = '0;
    end else begin
      if (do_deq) ent_d[0] = ent_q[1];
      if (do_enq) ent_d[count_after_deq[0]] = '{inst: enq_inst, pc: enq_pc};
      count_d = count_after_deq + {1'b0, do_enq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head_inst = ent_q[0].inst;
  assign head_pc   = ent_q[0].pc;
  assign count     = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, keeps one fetch outstanding to instruction
// memory and feeds returned words to the decoder through a 2-entry queue.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = ifu_fetch_pkg::RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [63:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc,
  input  logic        io_halt,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic [63:0] io_out_pc
);
  import ifu_fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;

  logic [1:0]   q_count;
  logic [31:0]  head_inst;
  logic [63:0]  head_pc;
  logic         req_fire, out_valid, q_enq, q_deq;

  always_comb begin
    // Gated by reset so no request escapes while memory is held in reset
    io_imem_req_valid = reset && (state_q == S_REQ) && !io_halt &&
                        (q_count < 2'(QDEPTH));
    req_fire  = io_imem_req_valid && io_imem_req_ready;
    out_valid = (q_count != 2'd0) && !io_redirect_valid;
    q_deq     = out_valid && io_out_ready;
    q_enq     = (state_q == S_WAIT) && io_imem_resp_valid && !drop_q &&
                !io_redirect_valid;

    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_imem_resp_valid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides the sequential PC and marks any in-flight word stale
    if (io_redirect_valid) begin
      pc_d = io_redirect_pc;
      if ((state_q == S_REQ) && req_fire) drop_d = 1'b1;
      if ((state_q == S_WAIT) && !io_imem_resp_valid) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  ifu_fetch_queue u_queue (
    .clk       (clock),
    .rst_n     (reset),
    .flush     (io_redirect_valid),
    .enq       (q_enq),
    .enq_inst  (io_imem_resp_data),
    .enq_pc    (req_pc_q),
    .deq       (q_deq),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .count     (q_count)
  );

  assign io_imem_req_addr = pc_q;
  assign io_out_valid     = out_valid;
  assign io_out_inst      = out_valid ? head_inst : '0;
  assign io_out_pc        = out_valid ? head_pc : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; the memory model answers each request with
// ~addr[31:0] after a programmable latency.
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [63:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_redirect_valid;
  logic [63:0] io_redirect_pc;
  logic        io_halt;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_inst;
  logic [63:0] io_out_pc;

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;
  logic [63:0] req_log[$];
  logic [63:0] out_pc_log[$];
  logic [31:0] out_inst_log[$];

  always #5 clock = ~clock;

  ifu_fetch dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_halt            (io_halt),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_inst        (io_out_inst),
    .io_out_pc          (io_out_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic drive_mem();
    io_imem_resp_valid = (pend_cnt == 1);
    io_imem_resp_data  = (pend_cnt == 1) ? ~pend_addr[31:0] : 32'h0;
    #2;
  endtask

  task automatic clk_edge();
    logic        fire;
    logic [63:0] addr;
    fire = io_imem_req_valid && io_imem_req_ready;
    addr = io_imem_req_addr;
    if (fire) req_log.push_back(addr);
    if (io_out_valid && io_out_ready) begin
      out_pc_log.push_back(io_out_pc);
      out_inst_log.push_back(io_out_inst);
    end
    @(posedge clock);
    #1;
    if (io_imem_resp_valid) pend_cnt = 0;
    else if (pend_cnt > 1) pend_cnt--;
    if (fire) begin
      pend_cnt  = lat;
      pend_addr = addr;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      drive_mem();
      clk_edge();
    end
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    io_imem_req_ready  = 1'b1;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_redirect_valid  = 1'b0;
    io_redirect_pc     = '0;
    io_halt            = 1'b0;
    io_out_ready       = 1'b1;
    pend_cnt           = 0;
    lat                = 1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_valid", io_imem_req_valid, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out_inst", io_out_inst, 0);
    check("rst_out_pc", io_out_pc, 0);
    check("rst_req_addr", io_imem_req_addr, 64'h8000_0000);
    reset = 1'b1;
    req_log.delete();
    out_pc_log.delete();
    out_inst_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: sequential fetch, one-cycle memory
    do_reset();
    drive_mem();
    check("t1_req_valid", io_imem_req_valid, 1);
    check("t1_req_addr0", io_imem_req_addr, 64'h8000_0000);
    check("t1_out_valid_c0", io_out_valid, 0);
    clk_edge();
    drive_mem();
    check("t1_out_valid_at_resp", io_out_valid, 0);
    clk_edge();
    drive_mem();
    check("t1_out_valid_after_resp", io_out_valid, 1);
    clk_edge();
    step(4);
    check("t1_req_count", 64'(req_log.size()), 4);
    check("t1_req_addr1", req_log[1], 64'h8000_0004);
    check("t1_req_addr2", req_log[2], 64'h8000_0008);
    check("t1_out_count", 64'(out_pc_log.size()), 3);
    check("t1_out_pc0", out_pc_log[0], 64'h8000_0000);
    check("t1_out_pc1", out_pc_log[1], 64'h8000_0004);
    check("t1_out_pc2", out_pc_log[2], 64'h8000_0008);
    check("t1_out_inst0", 64'(out_inst_log[0]), 64'h7FFF_FFFF);
    check("t1_out_inst1", 64'(out_inst_log[1]), 64'h7FFF_FFFB);
    check("t1_out_inst2", 64'(out_inst_log[2]), 64'h7FFF_FFF7);

    // 2: decoder stalled, queue fills to 2 then drains
    do_reset();
    io_out_ready = 1'b0;
    step(10);
    check("t2_req_count", 64'(req_log.size()), 2);
    io_out_ready = 1'b1;
    drive_mem();
    check("t2_full_req_valid", io_imem_req_valid, 0);
    check("t2_head_pc0", io_out_pc, 64'h8000_0000);
    check("t2_head_inst0", io_out_inst, 64'h7FFF_FFFF);
    clk_edge();
    drive_mem();
    check("t2_head_pc1", io_out_pc, 64'h8000_0004);
    check("t2_head_inst1", io_out_inst, 64'h7FFF_FFFB);
    check("t2_resume_req_valid", io_imem_req_valid, 1);
    check("t2_resume_addr", io_imem_req_addr, 64'h8000_0008);
    clk_edge();

    // 3: redirect while waiting; late response dropped
    do_reset();
    lat = 3;
    step(1);
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_0100;
    drive_mem();
    check("t3_redir_out_valid", io_out_valid, 0);
    clk_edge();
    io_redirect_valid = 1'b0;
    drive_mem();
    check("t3_wait_out_valid", io_out_valid, 0);
    clk_edge();
    drive_mem();
    check("t3_stale_resp", io_imem_resp_valid, 1);
    check("t3_wait_req_valid", io_imem_req_valid, 0);
    clk_edge();
    lat = 1;
    drive_mem();
    check("t3_no_stale_out", io_out_valid, 0);
    check("t3_new_req_valid", io_imem_req_valid, 1);
    check("t3_new_req_addr", io_imem_req_addr, 64'h8000_0100);
    clk_edge();
    drive_mem();
    check("t3_enq_out_valid", io_out_valid, 0);
    clk_edge();
    drive_mem();
    check("t3_out_pc", io_out_pc, 64'h8000_0100);
    check("t3_out_inst", io_out_inst, 64'h7FFF_FEFF);
    clk_edge();

    // 4: redirect coincident with response and output handshake
    do_reset();
    io_out_ready = 1'b0;
    step(3);
    io_out_ready      = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_0200;
    drive_mem();
    check("t4_resp_present", io_imem_resp_valid, 1);
    check("t4_out_valid_forced", io_out_valid, 0);
    check("t4_out_inst_forced", io_out_inst, 0);
    clk_edge();
    io_redirect_valid = 1'b0;
    drive_mem();
    check("t4_queue_empty", io_out_valid, 0);
    check("t4_req_valid", io_imem_req_valid, 1);
    check("t4_req_addr", io_imem_req_addr, 64'h8000_0200);
    clk_edge();

    // 5: halt with one fetch outstanding
    do_reset();
    lat = 2;
    step(1);
    io_halt = 1'b1;
    drive_mem();
    check("t5_wait_req_valid", io_imem_req_valid, 0);
    clk_edge();
    drive_mem();
    check("t5_resp_req_valid", io_imem_req_valid, 0);
    clk_edge();
    drive_mem();
    check("t5_halt_req_valid", io_imem_req_valid, 0);
    check("t5_out_valid", io_out_valid, 1);
    check("t5_out_pc", io_out_pc, 64'h8000_0000);
    check("t5_out_inst", io_out_inst, 64'h7FFF_FFFF);
    clk_edge();
    drive_mem();
    check("t5_drained", io_out_valid, 0);
    check("t5_still_halted", io_imem_req_valid, 0);
    clk_edge();
    io_halt = 1'b0;
    drive_mem();
    check("t5_resume_req_valid", io_imem_req_valid, 1);
    check("t5_resume_addr", io_imem_req_addr, 64'h8000_0004);
    clk_edge();

    // 6: reset asserted mid-operation
    do_reset();
    lat = 3;
    io_out_ready = 1'b0;
    step(5);
    drive_mem();
    check("t6_pre_out_valid", io_out_valid, 1);
    check("t6_pre_req_valid", io_imem_req_valid, 0);
    reset = 1'b0;
    #1;
    check("t6_async_out_valid", io_out_valid, 0);
    check("t6_async_out_pc", io_out_pc, 0);
    check("t6_async_req_valid", io_imem_req_valid, 0);
    do_reset();
    drive_mem();
    check("t6_post_req_valid", io_imem_req_valid, 1);
    check("t6_post_req_addr", io_imem_req_addr, 64'h8000_0000);
    check("t6_post_out_valid", io_out_valid, 0);
    clk_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
